id_rr_pipe_reg: RTL and testbench

Decode-to-register-read pipeline register for the IITB-RISC pipeline. It sits directly after the hazard detection unit and consumes its `should_stall`. It captures decoded instruction fields into the RR stage, inserts bubbles on stalls and flushes, and expands LM/SM instructions into one micro-op per selected register. It drives `decode_hold` so the IF and ID stages freeze while it is stalled or sequencing.

---
 rtl/iitb_pkg.sv | 17 +
 rtl/id_rr_pipe_reg_if.sv | 32 +++
 rtl/lsb_priority_enc.sv | 17 +
 rtl/id_rr_pipe_reg.sv | 146 ++++++++++++++
 tb/tb_id_rr_pipe_reg.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/iitb_pkg.sv
// Shared IITB-RISC definitions: opcodes, field widths and RR-stage FSM states.
package iitb_pkg;

  localparam logic [3:0] OP_NOP = 4'b1111;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;

  localparam int REG_IDX_W = 3;
  localparam int IMM_W     = 9;
  localparam int PC_W      = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } rr_state_t;

endpackage

// File: rtl/id_rr_pipe_reg_if.sv
// Decode-side fields into the ID/RR register and the registered RR-side fields out of it.
interface id_rr_pipe_reg_if;
  import iitb_pkg::*;

  logic                 dec_valid;
  logic [3:0]           dec_op;
  logic [REG_IDX_W-1:0] dec_src1;
  logic [REG_IDX_W-1:0] dec_src2;
  logic [REG_IDX_W-1:0] dec_dest;
  logic [IMM_W-1:0]     dec_imm;
  logic [PC_W-1:0]      dec_pc;

  logic                 rr_valid;
  logic [3:0]           rr_op;
  logic [REG_IDX_W-1:0] rr_src1;
  logic [REG_IDX_W-1:0] rr_src2;
  logic [REG_IDX_W-1:0] rr_dest;
  logic [IMM_W-1:0]     rr_imm;
  logic [PC_W-1:0]      rr_pc;
  logic                 decode_hold;

  modport master (
    output dec_valid, dec_op, dec_src1, dec_src2, dec_dest, dec_imm, dec_pc,
    input  rr_valid, rr_op, rr_src1, rr_src2, rr_dest, rr_imm, rr_pc, decode_hold
  );

  modport slave (
    input  dec_valid, dec_op, dec_src1, dec_src2, dec_dest, dec_imm, dec_pc,
    output rr_valid, rr_op, rr_src1, rr_src2, rr_dest, rr_imm, rr_pc, decode_hold
  );

endinterface

// File: rtl/lsb_priority_enc.sv
// Finds the lowest set bit of an 8-bit register mask and flags when it is the only one.
module lsb_priority_enc (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       one_hot_last
);

  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

  assign one_hot_last = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/id_rr_pipe_reg.sv
// ID->RR pipeline register: bubbles on stall/flush, expands LM/SM into per-register micro-ops.
module id_rr_pipe_reg
  import iitb_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  id_rr_pipe_reg_if.slave        bus,
  input  logic                   should_stall,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  rr_state_t            state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic [2:0]           off_q, off_d;
  logic                 valid_q, valid_d;
  logic [3:0]           op_q, op_d;
  logic [REG_IDX_W-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
  logic [IMM_W-1:0]     imm_q, imm_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 hold;

  logic [7:0] sel_mask;
  logic [2:0] enc_idx;
  logic       enc_last;
  logic       dec_is_lmsm;

  assign dec_is_lmsm = (bus.dec_op == OP_LM) || (bus.dec_op == OP_SM);
  assign sel_mask    = (state_q == ST_MULTI) ? rem_q : bus.dec_imm[7:0];

  lsb_priority_enc u_enc (
    .mask         (sel_mask),
    .idx          (enc_idx),
    .one_hot_last (enc_last)
  );

  // Priority: flush, then stall, then LM/SM sequencing, then plain capture.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    off_d   = off_q;
    valid_d = valid_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;

    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
      rem_d   = 8'd0;
      off_d   = 3'd0;
    end else if (should_stall) begin
      valid_d = 1'b0;
      hold    = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + STALL_CNT_W'(1);
    end else if (state_q == ST_MULTI) begin
      valid_d = 1'b1;
      imm_d   = IMM_W'(off_q);
      if (op_q == OP_LM) dest_d = enc_idx;
      else               src2_d = enc_idx;
      rem_d = rem_q & ~(8'd1 << enc_idx);
      off_d = off_q + 3'd1;
      if (enc_last) begin
        state_d = ST_IDLE;
        off_d   = 3'd0;
      end else begin
        hold = 1'b1;
      end
    end else if (bus.dec_valid && dec_is_lmsm) begin
      if (bus.dec_imm[7:0] == 8'd0) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        op_d    = bus.dec_op;
        src1_d  = bus.dec_src1;
        src2_d  = bus.dec_src2;
        dest_d  = bus.dec_dest;
        pc_d    = bus.dec_pc;
        imm_d   = '0;
        if (bus.dec_op == OP_LM) dest_d = enc_idx;
        else                     src2_d = enc_idx;
        if (!enc_last) begin
          state_d = ST_MULTI;
          rem_d   = bus.dec_imm[7:0] & ~(8'd1 << enc_idx);
          off_d   = 3'd1;
          hold    = 1'b1;
        end
      end
    end else begin
      valid_d = bus.dec_valid;
      op_d    = bus.dec_op;
      src1_d  = bus.dec_src1;
      src2_d  = bus.dec_src2;
      dest_d  = bus.dec_dest;
      imm_d   = bus.dec_imm;
      pc_d    = bus.dec_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
      off_q   <= 3'd0;
      valid_q <= 1'b0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dest_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      off_q   <= off_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rr_valid    = valid_q;
  assign bus.rr_op       = op_q;
  assign bus.rr_src1     = src1_q;
  assign bus.rr_src2     = src2_q;
  assign bus.rr_dest     = dest_q;
  assign bus.rr_imm      = imm_q;
  assign bus.rr_pc       = pc_q;
  assign bus.decode_hold = hold & reset_n;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_id_rr_pipe_reg.sv
// Directed-vector bench for id_rr_pipe_reg with hand-computed expectations.
module tb_id_rr_pipe_reg;
  import iitb_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        should_stall;
  logic        flush;
  logic [15:0] stall_count;

  int checks;
  int failures;

  id_rr_pipe_reg_if bus ();

  id_rr_pipe_reg #(.STALL_CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .should_stall (should_stall),
    .flush        (flush),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [2:0] s1,
                               input logic [2:0] s2, input logic [2:0] d, input logic [8:0] imm,
                               input logic [15:0] pc, input logic st, input logic fl);
    bus.dec_valid = v;
    bus.dec_op    = op;
    bus.dec_src1  = s1;
    bus.dec_src2  = s2;
    bus.dec_dest  = d;
    bus.dec_imm   = imm;
    bus.dec_pc    = pc;
    should_stall  = st;
    flush         = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int emitted;
    logic exp_hold;
    checks   = 0;
    failures = 0;

    // Reset state
    reset_n = 1'b0;
    applyStimulus(0, 4'd0, 0, 0, 0, 9'd0, 16'd0, 0, 0);
    tick();
    tick();
    checkOutput("reset_valid", 32'(bus.rr_valid), 0);
    checkOutput("reset_pc", 32'(bus.rr_pc), 0);
    checkOutput("reset_hold", 32'(bus.decode_hold), 0);
    checkOutput("reset_cnt", 32'(stall_count), 0);
    reset_n = 1'b1;

    // Plain ADD capture
    applyStimulus(1, 4'b0000, 3'd1, 3'd2, 3'd3, 9'd0, 16'h0010, 0, 0);
    #1 checkOutput("add_hold_pre", 32'(bus.decode_hold), 0);
    tick();
    checkOutput("add_valid", 32'(bus.rr_valid), 1);
    checkOutput("add_dest", 32'(bus.rr_dest), 3);
    checkOutput("add_src1", 32'(bus.rr_src1), 1);
    checkOutput("add_pc", 32'(bus.rr_pc), 16'h0010);
    checkOutput("add_hold_post", 32'(bus.decode_hold), 0);

    // Three stall cycles, held instruction emerges on the fourth
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b0001, 3'd1, 3'd2, 3'd4, 9'd0, 16'h0012, 1, 0);
      #1 checkOutput("stall_hold", 32'(bus.decode_hold), 1);
      tick();
      checkOutput("stall_valid", 32'(bus.rr_valid), 0);
      checkOutput("stall_pc_held", 32'(bus.rr_pc), 16'h0010);
    end
    checkOutput("stall_cnt3", 32'(stall_count), 3);
    applyStimulus(1, 4'b0001, 3'd1, 3'd2, 3'd4, 9'd0, 16'h0012, 0, 0);
    tick();
    checkOutput("unstall_valid", 32'(bus.rr_valid), 1);
    checkOutput("unstall_pc", 32'(bus.rr_pc), 16'h0012);
    checkOutput("unstall_dest", 32'(bus.rr_dest), 4);

    // LM mask 1010_0100 -> dest 2,5,7 with offsets 0,1,2
    applyStimulus(1, OP_LM, 3'd1, 3'd0, 3'd0, 9'h0A4, 16'h0020, 0, 0);
    #1 checkOutput("lm_hold0", 32'(bus.decode_hold), 1);
    tick();
    checkOutput("lm_v0", 32'(bus.rr_valid), 1);
    checkOutput("lm_dest0", 32'(bus.rr_dest), 2);
    checkOutput("lm_imm0", 32'(bus.rr_imm), 0);
    checkOutput("lm_op0", 32'(bus.rr_op), 32'(OP_LM));
    checkOutput("lm_pc0", 32'(bus.rr_pc), 16'h0020);
    applyStimulus(1, 4'b0000, 3'd2, 3'd3, 3'd1, 9'd0, 16'h0030, 0, 0);
    #1 checkOutput("lm_hold1", 32'(bus.decode_hold), 1);
    tick();
    checkOutput("lm_dest1", 32'(bus.rr_dest), 5);
    checkOutput("lm_imm1", 32'(bus.rr_imm), 1);
    checkOutput("lm_hold2", 32'(bus.decode_hold), 0);
    tick();
    checkOutput("lm_v2", 32'(bus.rr_valid), 1);
    checkOutput("lm_dest2", 32'(bus.rr_dest), 7);
    checkOutput("lm_imm2", 32'(bus.rr_imm), 2);
    checkOutput("lm_pc2", 32'(bus.rr_pc), 16'h0020);
    tick();
    checkOutput("after_lm_pc", 32'(bus.rr_pc), 16'h0030);
    checkOutput("after_lm_dest", 32'(bus.rr_dest), 1);

    // SM mask FF with a stall on the 4th micro-op: 9 cycles total
    applyStimulus(1, OP_SM, 3'd2, 3'd0, 3'd5, 9'h0FF, 16'h0040, 0, 0);
    emitted = 0;
    for (int c = 0; c < 9; c++) begin
      should_stall = (c == 3);
      exp_hold = (c == 3) || ((8 - emitted) > 1);
      #1 checkOutput("sm_hold", 32'(bus.decode_hold), 32'(exp_hold));
      tick();
      if (c == 0) bus.dec_valid = 1'b0;
      if (c == 3) begin
        checkOutput("sm_bubble", 32'(bus.rr_valid), 0);
      end else begin
        checkOutput("sm_valid", 32'(bus.rr_valid), 1);
        checkOutput("sm_src2", 32'(bus.rr_src2), 32'(emitted));
        checkOutput("sm_imm", 32'(bus.rr_imm), 32'(emitted));
        emitted++;
      end
    end
    checkOutput("sm_dest", 32'(bus.rr_dest), 5);
    checkOutput("sm_cnt", 32'(stall_count), 4);
    should_stall = 1'b0;
    tick();
    checkOutput("sm_done_valid", 32'(bus.rr_valid), 0);

    // Flush in MULTI after 2 of 4 LM bits, with stall also high
    applyStimulus(1, OP_LM, 3'd1, 3'd0, 3'd0, 9'h00F, 16'h0050, 0, 0);
    tick();
    bus.dec_valid = 1'b0;
    tick();
    checkOutput("fl_dest1", 32'(bus.rr_dest), 1);
    should_stall = 1'b1;
    flush        = 1'b1;
    #1 checkOutput("fl_hold", 32'(bus.decode_hold), 0);
    tick();
    checkOutput("fl_valid", 32'(bus.rr_valid), 0);
    checkOutput("fl_cnt", 32'(stall_count), 4);
    applyStimulus(1, 4'b0000, 3'd1, 3'd1, 3'd6, 9'd0, 16'h0060, 0, 0);
    #1 checkOutput("fl_idle_hold", 32'(bus.decode_hold), 0);
    tick();
    checkOutput("fl_idle_pc", 32'(bus.rr_pc), 16'h0060);
    checkOutput("fl_idle_dest", 32'(bus.rr_dest), 6);

    // Asynchronous reset in the middle of MULTI
    applyStimulus(1, OP_LM, 3'd1, 3'd0, 3'd0, 9'h00F, 16'h0070, 0, 0);
    tick();
    bus.dec_valid = 1'b0;
    checkOutput("rst_pre_hold", 32'(bus.decode_hold), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.rr_valid), 0);
    checkOutput("rst_pc", 32'(bus.rr_pc), 0);
    checkOutput("rst_op", 32'(bus.rr_op), 0);
    checkOutput("rst_hold", 32'(bus.decode_hold), 0);
    tick();
    reset_n = 1'b1;
    #1 checkOutput("rst_idle_hold", 32'(bus.decode_hold), 0);

    // LM with empty mask is dropped
    applyStimulus(1, OP_LM, 3'd1, 3'd0, 3'd0, 9'h000, 16'h0080, 0, 0);
    #1 checkOutput("lm0_hold", 32'(bus.decode_hold), 0);
    tick();
    checkOutput("lm0_valid", 32'(bus.rr_valid), 0);
    checkOutput("lm0_hold_post", 32'(bus.decode_hold), 0);

    // Saturating stall counter
    applyStimulus(0, 4'd0, 0, 0, 0, 9'd0, 16'd0, 1, 0);
    for (int i = 0; i < 65540; i++) tick();
    checkOutput("cnt_sat", 32'(stall_count), 32'h0000FFFF);
    should_stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
